jtag_tap_resp: RTL and testbench

- JTAG TAP responder: the target end of the TCK/TMS/TDI/TDO link that the controller-side JTAG shifter drives.
- Samples TCK, TMS and TDI as ordinary inputs in the FASTCLK domain and runs the IEEE 1149.1 16-state TAP controller.
- Implements IR, BYPASS, IDCODE and one user data register, and drives TDO.
- Uses: on-board loopback target for self-test of the controller-side shifter, and an emulated JTAG device in the bench.

---
 rtl/jtag_tap_pkg.sv | 54 +++++
 rtl/jtag_edge_sync.sv | 51 +++++
 rtl/jtag_tap_resp.sv | 131 +++++++++++++
 tb/tb_jtag_tap_resp.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP state encoding, DR selection and the 1149.1 next-state rule.
// Purely combinational definitions; no latency and no backpressure.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR   = 4'hF,
    RTI   = 4'hC,
    SELDR = 4'h7,
    CAPDR = 4'h6,
    SHDR  = 4'h2,
    EX1DR = 4'h1,
    PADR  = 4'h3,
    EX2DR = 4'h0,
    UPDR  = 4'h5,
    SELIR = 4'h4,
    CAPIR = 4'hE,
    SHIR  = 4'hA,
    EX1IR = 4'h9,
    PAIR  = 4'hB,
    EX2IR = 4'h8,
    UPIR  = 4'hD
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_t;

  localparam int IDCODE_LEN = 32;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR   : RTI;
      RTI:     return tms ? SELDR : RTI;
      SELDR:   return tms ? SELIR : CAPDR;
      CAPDR:   return tms ? EX1DR : SHDR;
      SHDR:    return tms ? EX1DR : SHDR;
      EX1DR:   return tms ? UPDR  : PADR;
      PADR:    return tms ? EX2DR : PADR;
      EX2DR:   return tms ? UPDR  : SHDR;
      UPDR:    return tms ? SELDR : RTI;
      SELIR:   return tms ? TLR   : CAPIR;
      CAPIR:   return tms ? EX1IR : SHIR;
      SHIR:    return tms ? EX1IR : SHIR;
      EX1IR:   return tms ? UPIR  : PAIR;
      PAIR:    return tms ? EX2IR : PAIR;
      EX2IR:   return tms ? UPIR  : SHIR;
      UPIR:    return tms ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_edge_sync.sv
// Synchronises TCK/TMS/TDI into the fast clock and emits single-cycle TCK rise/fall pulses.
// Pin edge to pulse-driven action is 3 cycles; no backpressure, short TCK phases may be lost.
module jtag_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tck,
  input  logic i_tms,
  input  logic i_tdi,
  output logic o_rise,
  output logic o_fall,
  output logic o_tms,
  output logic o_tdi
);

  logic       r_tck_s1, r_tck_s2, r_tck_s3;
  logic       r_tms_s1, r_tms_s2;
  logic       r_tdi_s1, r_tdi_s2;
  logic [1:0] r_fill;
  logic       r_armed;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tck_s1 <= 1'b0;
      r_tck_s2 <= 1'b0;
      r_tck_s3 <= 1'b0;
      r_tms_s1 <= 1'b0;
      r_tms_s2 <= 1'b0;
      r_tdi_s1 <= 1'b0;
      r_tdi_s2 <= 1'b0;
      r_fill   <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_tck_s1 <= i_tck;
      r_tck_s2 <= r_tck_s1;
      r_tck_s3 <= r_tck_s2;
      r_tms_s1 <= i_tms;
      r_tms_s2 <= r_tms_s1;
      r_tdi_s1 <= i_tdi;
      r_tdi_s2 <= r_tdi_s1;
      r_fill   <= {r_fill[0], 1'b1};
      // Rises count only once TCK has been seen low, so a TCK held high through reset is not an edge.
      if (r_fill[1] && !r_tck_s2) r_armed <= 1'b1;
    end
  end

  assign o_rise = r_tck_s2 & ~r_tck_s3 & r_armed;
  assign o_fall = ~r_tck_s2 & r_tck_s3;
  assign o_tms  = r_tms_s2;
  assign o_tdi  = r_tdi_s2;

endmodule

// File: rtl/jtag_tap_resp.sv
// JTAG TAP responder (IR, BYPASS, IDCODE, USER DR) running on FASTCLK from sampled TCK/TMS/TDI.
// Actions land 3 FASTCLK cycles after a TCK pin edge; no backpressure, TCK phases must last >=4 cycles.
module jtag_tap_resp import jtag_tap_pkg::*; #(
  parameter int                  IR_WIDTH   = 8,
  parameter int                  DR_WIDTH   = 16,
  parameter logic [31:0]         IDCODE_VAL = 32'h1DB7_0093,
  parameter logic [IR_WIDTH-1:0] IDCODE_INS = IR_WIDTH'(8'h01),
  parameter logic [IR_WIDTH-1:0] USER_INS   = IR_WIDTH'(8'h02)
) (
  input  logic                FASTCLK,
  input  logic                RST,
  input  logic                TCK,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  input  logic [DR_WIDTH-1:0] USER_DIN,
  output logic [DR_WIDTH-1:0] USER_DOUT,
  output logic                UPDATE_STB,
  output logic                CAPTURE_STB,
  output logic [3:0]          TAP_STATE,
  output logic [IR_WIDTH-1:0] IR_OUT
);

  localparam int SH_W     = (DR_WIDTH > IDCODE_LEN) ? DR_WIDTH : IDCODE_LEN;
  localparam int SH_IDX_W = $clog2(SH_W);

  tap_state_t          r_state, w_state_nxt;
  dr_sel_t             w_sel;
  logic                w_rise, w_fall, w_tms, w_tdi;
  logic [IR_WIDTH-1:0] r_ir, r_ir_sh;
  logic [SH_W-1:0]     r_dr_sh, w_dr_shifted, w_dr_cap;
  logic [SH_IDX_W-1:0] w_msb;
  logic [DR_WIDTH-1:0] r_user_dout;
  logic                r_tdo, r_tdo_en, r_upd_stb, r_cap_stb;

  jtag_edge_sync u_sync (
    .i_clk  (FASTCLK),
    .i_rst  (RST),
    .i_tck  (TCK),
    .i_tms  (TMS),
    .i_tdi  (TDI),
    .o_rise (w_rise),
    .o_fall (w_fall),
    .o_tms  (w_tms),
    .o_tdi  (w_tdi)
  );

  always_ff @(posedge FASTCLK) begin
    if (RST) r_state <= TLR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_rise) w_state_nxt = tap_next(r_state, w_tms);
  end

  always_comb begin
    w_sel = DR_BYPASS;
    if (r_ir == IDCODE_INS)    w_sel = DR_IDCODE;
    else if (r_ir == USER_INS) w_sel = DR_USER;
  end

  // One shifter serves every DR; TDI enters at the MSB of whichever length is selected.
  always_comb begin
    w_msb    = '0;
    w_dr_cap = '0;
    case (w_sel)
      DR_IDCODE: begin
        w_msb    = SH_IDX_W'(IDCODE_LEN - 1);
        w_dr_cap = SH_W'(IDCODE_VAL);
      end
      DR_USER: begin
        w_msb    = SH_IDX_W'(DR_WIDTH - 1);
        w_dr_cap = SH_W'(USER_DIN);
      end
      default: ;
    endcase
    w_dr_shifted        = r_dr_sh >> 1;
    w_dr_shifted[w_msb] = w_tdi;
  end

  always_ff @(posedge FASTCLK) begin
    if (RST) begin
      r_ir        <= IDCODE_INS;
      r_ir_sh     <= '0;
      r_dr_sh     <= '0;
      r_user_dout <= '0;
      r_tdo       <= 1'b0;
      r_tdo_en    <= 1'b0;
      r_upd_stb   <= 1'b0;
      r_cap_stb   <= 1'b0;
    end else begin
      r_upd_stb <= 1'b0;
      r_cap_stb <= 1'b0;
      if (w_rise) begin
        case (r_state)
          TLR:   r_ir <= IDCODE_INS;
          CAPDR: begin
            r_dr_sh   <= w_dr_cap;
            r_cap_stb <= (w_sel == DR_USER);
          end
          SHDR:  r_dr_sh <= w_dr_shifted;
          CAPIR: r_ir_sh <= IR_WIDTH'(2'b01);
          SHIR:  r_ir_sh <= {w_tdi, r_ir_sh[IR_WIDTH-1:1]};
          default: ;
        endcase
      end
      if (w_fall) begin
        r_tdo_en <= (r_state == SHDR) || (r_state == SHIR);
        if (r_state == SHDR)      r_tdo <= r_dr_sh[0];
        else if (r_state == SHIR) r_tdo <= r_ir_sh[0];
        if (r_state == UPIR) r_ir <= r_ir_sh;
        if (r_state == UPDR && w_sel == DR_USER) begin
          r_user_dout <= r_dr_sh[DR_WIDTH-1:0];
          r_upd_stb   <= 1'b1;
        end
      end
    end
  end

  assign TDO         = r_tdo;
  assign TDO_EN      = r_tdo_en;
  assign USER_DOUT   = r_user_dout;
  assign UPDATE_STB  = r_upd_stb;
  assign CAPTURE_STB = r_cap_stb;
  assign TAP_STATE   = r_state;
  assign IR_OUT      = r_ir;

endmodule

// File: tb/tb_jtag_tap_resp.sv
// Bench for jtag_tap_resp: random IR/DR scans against a queue-based shift model,
// with independent monitors for TDO and the USER update/capture strobes.
module tb_jtag_tap_resp;

  localparam int          IRW = 8;
  localparam int          DRW = 16;
  localparam logic [31:0] IDV = 32'h1DB7_0093;
  localparam logic [7:0]  IDI = 8'h01;
  localparam logic [7:0]  USI = 8'h02;

  logic           FASTCLK = 1'b0;
  logic           RST = 1'b1;
  logic           TCK = 1'b0;
  logic           TMS = 1'b1;
  logic           TDI = 1'b0;
  logic [DRW-1:0] USER_DIN = '0;
  logic           TDO, TDO_EN, UPDATE_STB, CAPTURE_STB;
  logic [DRW-1:0] USER_DOUT;
  logic [3:0]     TAP_STATE;
  logic [IRW-1:0] IR_OUT;

  always #5 FASTCLK = ~FASTCLK;

  jtag_tap_resp #(
    .IR_WIDTH(IRW), .DR_WIDTH(DRW), .IDCODE_VAL(IDV), .IDCODE_INS(IDI), .USER_INS(USI)
  ) dut (
    .FASTCLK(FASTCLK), .RST(RST), .TCK(TCK), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .TDO_EN(TDO_EN), .USER_DIN(USER_DIN), .USER_DOUT(USER_DOUT),
    .UPDATE_STB(UPDATE_STB), .CAPTURE_STB(CAPTURE_STB),
    .TAP_STATE(TAP_STATE), .IR_OUT(IR_OUT)
  );

  int             n_checks = 0;
  int             n_errors = 0;
  bit             exp_tdo_q[$];
  logic [DRW-1:0] exp_dout_q[$];
  bit             sh_q[$];
  int             exp_cap = 0;
  int             got_cap = 0;
  logic [7:0]     m_ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  // TDO monitor: every TCK fall that leaves TDO_EN high must deliver the next expected bit.
  initial begin
    forever begin
      @(negedge TCK);
      repeat (5) @(negedge FASTCLK);
      if (TDO_EN === 1'b1) begin
        if (exp_tdo_q.size() == 0) fail_now("tdo_en_unexpected");
        else begin
          bit e;
          e = exp_tdo_q.pop_front();
          check("tdo_bit", {31'b0, TDO}, {31'b0, e});
        end
      end
    end
  end

  logic prev_upd = 1'b0;
  logic prev_cap = 1'b0;
  always @(negedge FASTCLK) begin
    if (UPDATE_STB === 1'b1 && prev_upd !== 1'b1) begin
      if (exp_dout_q.size() == 0) fail_now("update_stb_unexpected");
      else begin
        logic [DRW-1:0] e;
        e = exp_dout_q.pop_front();
        check("user_dout", {16'b0, USER_DOUT}, {16'b0, e});
      end
    end
    if (UPDATE_STB === 1'b1 && prev_upd === 1'b1) fail_now("update_stb_width");
    if (CAPTURE_STB === 1'b1 && prev_cap !== 1'b1) got_cap++;
    if (CAPTURE_STB === 1'b1 && prev_cap === 1'b1) fail_now("capture_stb_width");
    prev_upd = UPDATE_STB;
    prev_cap = CAPTURE_STB;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tck(input logic tms, input logic tdi);
    @(negedge FASTCLK);
    TMS = tms;
    TDI = tdi;
    repeat (6) @(negedge FASTCLK);
    TCK = 1'b1;
    repeat (6) @(negedge FASTCLK);
    TCK = 1'b0;
  endtask

  function automatic int dr_len(input logic [7:0] ir);
    if (ir == IDI) return 32;
    if (ir == USI) return DRW;
    return 1;
  endfunction

  function automatic logic [31:0] dr_cap(input logic [7:0] ir);
    if (ir == IDI) return IDV;
    if (ir == USI) return {16'b0, USER_DIN};
    return 32'b0;
  endfunction

  task automatic settle_rti(input string name);
    repeat (6) @(negedge FASTCLK);
    check(name, {28'b0, TAP_STATE}, 32'hC);
  endtask

  // From RTI: load IR with v and return to RTI.
  task automatic scan_ir(input logic [7:0] v);
    for (int k = 0; k < IRW; k++) exp_tdo_q.push_back(k == 0);
    tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
    for (int k = 0; k < IRW; k++) tck(k == IRW - 1, v[k]);
    tck(1, 0); tck(0, 0);
    m_ir = v;
    settle_rti("ir_scan_state");
    check("ir_out", {24'b0, IR_OUT}, {24'b0, v});
  endtask

  // From RTI: capture, shift n bits of data LSB-first, update, return to RTI.
  task automatic scan_dr(input int n, input logic [63:0] data);
    int          len;
    logic [31:0] cap;
    logic [DRW-1:0] d;
    len = dr_len(m_ir);
    cap = dr_cap(m_ir);
    sh_q.delete();
    for (int i = 0; i < len; i++) sh_q.push_back(cap[i]);
    for (int k = 0; k < n; k++) begin
      exp_tdo_q.push_back(sh_q[0]);
      void'(sh_q.pop_front());
      sh_q.push_back(data[k]);
    end
    if (m_ir == USI) begin
      for (int i = 0; i < DRW; i++) d[i] = sh_q[i];
      exp_dout_q.push_back(d);
      exp_cap++;
    end
    tck(1, 0); tck(0, 0); tck(0, 0);
    for (int k = 0; k < n; k++) tck(k == n - 1, data[k]);
    tck(1, 0); tck(0, 0);
    settle_rti("dr_scan_state");
  endtask

  initial begin
    logic [7:0] ir;
    RST = 1'b1;
    repeat (4) @(negedge FASTCLK);
    check("rst_state", {28'b0, TAP_STATE}, 32'hF);
    check("rst_ir", {24'b0, IR_OUT}, {24'b0, IDI});
    check("rst_tdo_en", {31'b0, TDO_EN}, 32'h0);
    check("rst_dout", {16'b0, USER_DOUT}, 32'h0);
    RST = 1'b0;
    m_ir = IDI;

    for (int i = 0; i < 6; i++) tck(1, 0);
    repeat (6) @(negedge FASTCLK);
    check("tlr_hold_state", {28'b0, TAP_STATE}, 32'hF);
    check("tlr_hold_ir", {24'b0, IR_OUT}, {24'b0, IDI});
    tck(0, 0);
    settle_rti("enter_rti");

    scan_dr(32, {$urandom, $urandom});

    // Reset in the middle of a USER shift: no update, state back to TLR.
    scan_ir(USI);
    USER_DIN = 16'hBEEF;
    for (int k = 0; k < 4; k++) exp_tdo_q.push_back(USER_DIN[k]);
    exp_cap++;
    tck(1, 0); tck(0, 0); tck(0, 0);
    for (int k = 0; k < 3; k++) tck(0, 1'($urandom));
    repeat (6) @(negedge FASTCLK);
    RST = 1'b1;
    @(negedge FASTCLK);
    check("midrst_state", {28'b0, TAP_STATE}, 32'hF);
    check("midrst_dout", {16'b0, USER_DOUT}, 32'h0);
    check("midrst_tdo_en", {31'b0, TDO_EN}, 32'h0);
    check("midrst_tdo", {31'b0, TDO}, 32'h0);
    check("midrst_ir", {24'b0, IR_OUT}, {24'b0, IDI});
    RST = 1'b0;
    m_ir = IDI;
    tck(0, 0);
    settle_rti("post_rst_rti");

    scan_ir(USI);
    USER_DIN = 16'($urandom);
    scan_dr(16, 64'hA5C3);
    USER_DIN = 16'h1234;
    scan_dr(16, {$urandom, $urandom});

    scan_ir(8'hFF);
    scan_dr(4, 64'b1101);

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0: ir = IDI;
        1: ir = USI;
        2: ir = 8'($urandom);
        default: ir = 8'hFF;
      endcase
      scan_ir(ir);
      USER_DIN = 16'($urandom);
      scan_dr($urandom_range(1, dr_len(m_ir) + 4), {$urandom, $urandom});
    end

    for (int i = 0; i < 5; i++) tck(1, 0);
    repeat (6) @(negedge FASTCLK);
    check("final_tlr", {28'b0, TAP_STATE}, 32'hF);

    repeat (20) @(negedge FASTCLK);
    check("tdo_leftover", exp_tdo_q.size(), 32'd0);
    check("dout_leftover", exp_dout_q.size(), 32'd0);
    check("capture_count", got_cap, exp_cap);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
